// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
//
// Decides whether the instruction sitting in ID must be held back this cycle.
// Three sources of stall:
//   * RAW dependence on the EXE or MEM stage destination (forwarding off), or
//     a load-use dependence on EXE only (forwarding on);
//   * a multi-cycle MULT still occupying EXE after its issue cycle;
// and it keeps a saturating count of stalled cycles for performance analysis.
//
// Ports
//   clk, rst            pipeline clock (rising edge), async active-high reset
//   id_valid            ID holds a real instruction (0 = bubble)
//   src1, src2, two_src ID source registers; two_src says src2 is really read
//   id_is_mult          ID instruction is a MULT
//   exe_dest, exe_wb_en, exe_mem_r_en   EXE-stage destination / writes RF / is LD
//   mem_dest, mem_wb_en                 MEM-stage destination / writes RF
//   forward_en          forwarding unit active
//   stall_count_clr     synchronous clear of stall_count
//   hazard_detected     stall request to the ID controller
//   freeze              holds PC and IF/ID (identical to hazard_detected)
//   mult_busy           a MULT occupies EXE beyond its issue cycle
//   stall_count         saturating number of cycles with hazard_detected = 1
// -----------------------------------------------------------------------------
module hazard_detection_unit #(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       src1,
    input  logic [4:0]       src2,
    input  logic             two_src,
    input  logic             id_is_mult,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             forward_en,
    input  logic             stall_count_clr,
    output logic             hazard_detected,
    output logic             freeze,
    output logic             mult_busy,
    output logic [CNT_W-1:0] stall_count
);

    // Value loaded on MULT issue: the issue cycle itself is not stalled,
    // so only the remaining MULT_CYCLES-1 cycles are counted down.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);

    logic [3:0]       cnt_reg;
    logic [CNT_W-1:0] stall_count_reg;

    // Per-stage source match; index 0 = EXE, 1 = MEM.
    logic [4:0] stage_dest [2];
    logic [1:0] stage_match;

    assign stage_dest[0] = exe_dest;
    assign stage_dest[1] = mem_dest;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            // Register 0 is hard-wired and never creates a dependence.
            assign stage_match[gi] = (stage_dest[gi] != 5'd0) &&
                                     ((src1 == stage_dest[gi]) ||
                                      (two_src && (src2 == stage_dest[gi])));
        end
    endgenerate

    logic raw_hz;
    logic mult_issue;

    always_comb begin
        raw_hz = 1'b0;
        if (id_valid) begin
            if (forward_en) begin
                // With forwarding only a load in EXE cannot supply its value in time.
                raw_hz = exe_mem_r_en && stage_match[0];
            end else begin
                raw_hz = (exe_wb_en && stage_match[0]) || (mem_wb_en && stage_match[1]);
            end
        end
    end

    assign mult_busy       = (cnt_reg != 4'd0);
    assign hazard_detected = raw_hz || mult_busy;
    assign freeze          = hazard_detected;
    assign stall_count     = stall_count_reg;

    // A MULT stalled for any reason (data dependence or an earlier MULT) does not issue.
    assign mult_issue = id_valid && id_is_mult && !hazard_detected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= 4'd0;
        end else if (mult_issue) begin
            cnt_reg <= MULT_LOAD;
        end else if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_reg <= '0;
        end else if (stall_count_clr) begin
            stall_count_reg <= '0;
        end else if (hazard_detected && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_reg <= stall_count_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, two_src, id_is_mult;
    logic [4:0]  src1, src2, exe_dest, mem_dest;
    logic        exe_wb_en, exe_mem_r_en, mem_wb_en, forward_en, stall_count_clr;

    logic        hazard_detected, freeze, mult_busy;
    logic [31:0] stall_count;
    logic        hz_s, fr_s, busy_s;
    logic [2:0]  stall_count_s;
    logic        hz_m1, fr_m1, busy_m1;
    logic [31:0] stall_count_m1;

    always #5 clk = ~clk;

    hazard_detection_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .id_is_mult(id_is_mult), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .forward_en(forward_en), .stall_count_clr(stall_count_clr),
        .hazard_detected(hazard_detected), .freeze(freeze), .mult_busy(mult_busy),
        .stall_count(stall_count)
    );

    // Narrow counter copy so saturation is reachable in a few cycles.
    hazard_detection_unit #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .id_is_mult(id_is_mult), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .forward_en(forward_en), .stall_count_clr(stall_count_clr),
        .hazard_detected(hz_s), .freeze(fr_s), .mult_busy(busy_s),
        .stall_count(stall_count_s)
    );

    // Single-cycle MULT copy: must never report mult_busy.
    hazard_detection_unit #(.MULT_CYCLES(1)) dut_m1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .id_is_mult(id_is_mult), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .forward_en(forward_en), .stall_count_clr(stall_count_clr),
        .hazard_detected(hz_m1), .freeze(fr_m1), .mult_busy(busy_m1),
        .stall_count(stall_count_m1)
    );

    typedef struct {
        string       name;
        logic        hz;
        logic        busy;
        logic [31:0] cnt;
        bit          chk_cnt;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic two, input logic mult, input logic [4:0] ed,
                         input logic ewb, input logic emr, input logic [4:0] md,
                         input logic mwb, input logic fwd);
        id_valid = v; src1 = s1; src2 = s2; two_src = two; id_is_mult = mult;
        exe_dest = ed; exe_wb_en = ewb; exe_mem_r_en = emr;
        mem_dest = md; mem_wb_en = mwb; forward_en = fwd;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stall_count_clr = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        // While in reset the combinational hazard path stays live.
        rst = 1'b1;
        drive(1, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        sbq.push_back('{"reset_raw", 1'b1, 1'b0, 32'd0, 1'b1});
        #1;
        e = sbq.pop_front();
        total++; if (hazard_detected !== e.hz) begin bad++; $display("FAIL %s hazard_detected got=%b exp=%b", e.name, hazard_detected, e.hz); end
        total++; if (freeze !== e.hz) begin bad++; $display("FAIL %s freeze got=%b exp=%b", e.name, freeze, e.hz); end
        total++; if (mult_busy !== e.busy) begin bad++; $display("FAIL %s mult_busy got=%b exp=%b", e.name, mult_busy, e.busy); end
        total++; if (stall_count !== e.cnt) begin bad++; $display("FAIL %s stall_count got=%0d exp=%0d", e.name, stall_count, e.cnt); end
        $display("txn %s hz=%b busy=%b cnt=%0d", e.name, hazard_detected, mult_busy, stall_count);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Table-driven combinational cases; k selects the vector.
    task automatic test_raw_table(input int which);
        exp_t e;
        logic h;
        int   n;
        do_reset();
        n = (which == 0) ? 6 : (which == 1) ? 5 : 3;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            h = 1'b0;
            if (which == 0) begin
                case (k)
                    0: begin drive(1, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0); h = 1'b1; end
                    1: begin drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); h = 1'b0; end
                    2: begin drive(1, 1, 3, 0, 0, 3, 1, 0, 0, 0, 0); h = 1'b0; end
                    3: begin drive(1, 1, 3, 1, 0, 3, 1, 0, 0, 0, 0); h = 1'b1; end
                    4: begin drive(1, 4, 0, 0, 0, 0, 0, 0, 4, 1, 0); h = 1'b1; end
                    default: begin drive(1, 4, 0, 0, 0, 0, 0, 0, 4, 0, 0); h = 1'b0; end
                endcase
            end else if (which == 1) begin
                case (k)
                    0: begin drive(1, 1, 5, 1, 0, 5, 1, 1, 0, 0, 1); h = 1'b1; end
                    1: begin drive(1, 1, 5, 1, 0, 5, 1, 0, 0, 0, 1); h = 1'b0; end
                    2: begin drive(1, 1, 5, 1, 0, 7, 1, 0, 5, 1, 1); h = 1'b0; end
                    3: begin drive(1, 1, 5, 0, 0, 5, 1, 1, 0, 0, 1); h = 1'b0; end
                    default: begin drive(1, 1, 5, 1, 0, 7, 1, 0, 5, 1, 0); h = 1'b1; end
                endcase
            end else begin
                case (k)
                    0: begin drive(0, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0); h = 1'b0; end
                    1: begin drive(1, 3, 0, 0, 1, 3, 1, 0, 0, 0, 0); h = 1'b1; end
                    default: begin drive(1, 3, 0, 0, 0, 3, 0, 0, 0, 0, 0); h = 1'b0; end
                endcase
            end
            sbq.push_back('{$sformatf("tbl%0d_%0d", which, k), h, 1'b0, 32'd0, 1'b0});
            @(negedge clk);
            e = sbq.pop_front();
            total++; if (hazard_detected !== e.hz) begin bad++; $display("FAIL %s hazard_detected got=%b exp=%b", e.name, hazard_detected, e.hz); end
            total++; if (freeze !== e.hz) begin bad++; $display("FAIL %s freeze got=%b exp=%b", e.name, freeze, e.hz); end
            total++; if (mult_busy !== e.busy) begin bad++; $display("FAIL %s mult_busy got=%b exp=%b", e.name, mult_busy, e.busy); end
            $display("txn %s hz=%b busy=%b", e.name, hazard_detected, mult_busy);
        end
    endtask

    task automatic test_mult();
        exp_t       e;
        logic [9:0] mult_bits = 10'b0111110001;
        logic [9:0] stall_bits = 10'b1011101110;
        int         cnt_e[10];
        logic [2:0] es;
        cnt_e = '{0, 0, 1, 2, 3, 3, 4, 5, 6, 6};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            drive(1, 1, 2, 1, mult_bits[k], 0, 0, 0, 0, 0, 0);
            sbq.push_back('{$sformatf("mult_%0d", k), stall_bits[k], stall_bits[k], 32'(cnt_e[k]), 1'b1});
            @(negedge clk);
            e = sbq.pop_front();
            es = (e.cnt > 32'd7) ? 3'd7 : e.cnt[2:0];
            total++; if (hazard_detected !== e.hz) begin bad++; $display("FAIL %s hazard_detected got=%b exp=%b", e.name, hazard_detected, e.hz); end
            total++; if (freeze !== e.hz) begin bad++; $display("FAIL %s freeze got=%b exp=%b", e.name, freeze, e.hz); end
            total++; if (mult_busy !== e.busy) begin bad++; $display("FAIL %s mult_busy got=%b exp=%b", e.name, mult_busy, e.busy); end
            total++; if (stall_count !== e.cnt) begin bad++; $display("FAIL %s stall_count got=%0d exp=%0d", e.name, stall_count, e.cnt); end
            total++; if (stall_count_s !== es) begin bad++; $display("FAIL %s stall_count_narrow got=%0d exp=%0d", e.name, stall_count_s, es); end
            total++; if (busy_m1 !== 1'b0) begin bad++; $display("FAIL %s mult_busy_m1 got=%b exp=0", e.name, busy_m1); end
            $display("txn %s hz=%b busy=%b cnt=%0d", e.name, hazard_detected, mult_busy, stall_count);
        end
    endtask

    task automatic test_reset_mid_mult();
        exp_t       e;
        logic [2:0] stall_bits = 3'b110;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) do_reset();
            if (k == 3) begin
                // Asynchronous reset in the middle of the cycle, released before the next edge.
                rst = 1'b1;
                #1;
                sbq.push_back('{"mid_rst", 1'b0, 1'b0, 32'd0, 1'b1});
            end else begin
                @(posedge clk); #1;
                drive(1, 1, 2, 1, (k == 0) ? 1'b1 : 1'b0, 0, 0, 0, 0, 0, 0);
                sbq.push_back('{$sformatf("rmult_%0d", k), stall_bits[k], stall_bits[k], 32'(k == 2 ? 1 : 0), 1'b1});
                @(negedge clk);
            end
            e = sbq.pop_front();
            total++; if (hazard_detected !== e.hz) begin bad++; $display("FAIL %s hazard_detected got=%b exp=%b", e.name, hazard_detected, e.hz); end
            total++; if (mult_busy !== e.busy) begin bad++; $display("FAIL %s mult_busy got=%b exp=%b", e.name, mult_busy, e.busy); end
            total++; if (stall_count !== e.cnt) begin bad++; $display("FAIL %s stall_count got=%0d exp=%0d", e.name, stall_count, e.cnt); end
            $display("txn %s hz=%b busy=%b cnt=%0d", e.name, hazard_detected, mult_busy, stall_count);
            if (k == 3) begin
                #1 rst = 1'b0;
            end
        end
        // Next ID instruction after the reset pulse proceeds.
        @(posedge clk); #1;
        drive(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        sbq.push_back('{"post_rst", 1'b0, 1'b0, 32'd0, 1'b1});
        @(negedge clk);
        e = sbq.pop_front();
        total++; if (hazard_detected !== e.hz) begin bad++; $display("FAIL %s hazard_detected got=%b exp=%b", e.name, hazard_detected, e.hz); end
        total++; if (mult_busy !== e.busy) begin bad++; $display("FAIL %s mult_busy got=%b exp=%b", e.name, mult_busy, e.busy); end
        total++; if (stall_count !== e.cnt) begin bad++; $display("FAIL %s stall_count got=%0d exp=%0d", e.name, stall_count, e.cnt); end
        $display("txn %s hz=%b busy=%b cnt=%0d", e.name, hazard_detected, mult_busy, stall_count);
    endtask

    task automatic test_saturation();
        exp_t       e;
        logic [2:0] es;
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k <= 9) drive(1, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            // Clear coincides with a stall on the last stalled cycle.
            stall_count_clr = (k == 9);
            sbq.push_back('{$sformatf("sat_%0d", k), (k <= 9), 1'b0, 32'((k <= 9) ? k : 0), 1'b1});
            @(negedge clk);
            e = sbq.pop_front();
            es = (e.cnt > 32'd7) ? 3'd7 : e.cnt[2:0];
            total++; if (hazard_detected !== e.hz) begin bad++; $display("FAIL %s hazard_detected got=%b exp=%b", e.name, hazard_detected, e.hz); end
            total++; if (stall_count !== e.cnt) begin bad++; $display("FAIL %s stall_count got=%0d exp=%0d", e.name, stall_count, e.cnt); end
            total++; if (stall_count_s !== es) begin bad++; $display("FAIL %s stall_count_narrow got=%0d exp=%0d", e.name, stall_count_s, es); end
            $display("txn %s hz=%b cnt=%0d cnt_narrow=%0d", e.name, hazard_detected, stall_count, stall_count_s);
        end
        stall_count_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stall_count_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_raw_table(0);
        test_raw_table(1);
        test_raw_table(2);
        test_mult();
        test_reset_mid_mult();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
